// File: rtl/shift_register_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : shift_register_sequencer_if                                 |
// | Brief  : Command handshake plus shift-register control/feedback bus. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface shift_register_sequencer_if #(
  parameter int W  = 3,
  parameter int CW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data;
  logic          cmd_dir;
  logic [CW-1:0] cmd_count;
  logic          cmd_ser;
  logic          cmd_rot;
  logic          s1;
  logic          s0;
  logic [W-1:0]  I_par;
  logic          MSB_in;
  logic          LSB_in;
  logic [W-1:0]  A_par;
  logic          done;
  logic [W-1:0]  result;

  // The master side is both the host and the owned register (it returns A_par).
  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_ser, cmd_rot, A_par,
    input  cmd_ready, s1, s0, I_par, MSB_in, LSB_in, done, result
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_ser, cmd_rot, A_par,
    output cmd_ready, s1, s0, I_par, MSB_in, LSB_in, done, result
  );
endinterface
`default_nettype wire

// File: rtl/shift_register_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : shift_register_sequencer                                    |
// | Brief  : Runs load + N shifts on a universal shift register per cmd. |
// |          Optional rotate mode: define SHIFT_SEQ_ROTATE_EN.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module shift_register_sequencer #(
  parameter int W  = 3,
  parameter int CW = 4
) (
  input  logic                     CLK,
  input  logic                     Clear,
  shift_register_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_data;
  logic [W-1:0]  r_result;
  logic          r_dir;
  logic          r_ser;
  logic          r_done;
  logic          w_ready;
  logic          w_accept;
  logic          w_s1;
  logic          w_s0;
  logic          w_msb;
  logic          w_lsb;
  logic          w_fill;

  assign w_accept = bus.cmd_valid & w_ready;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic r_rot;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_rot <= 1'b0;
    end else if (w_accept) begin
      r_rot <= bus.cmd_rot;
    end
  end

  // Rotation feeds back the bit that falls off the far end.
  assign w_fill = r_rot ? (r_dir ? bus.A_par[W-1] : bus.A_par[0]) : r_ser;
`else
  logic w_unused_rot;
  assign w_unused_rot = bus.cmd_rot;
  assign w_fill       = r_ser;
`endif

  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_dir    <= 1'b0;
      r_ser    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_DONE);
      if (w_accept) begin
        r_data <= bus.cmd_data;
        r_dir  <= bus.cmd_dir;
        r_ser  <= bus.cmd_ser;
        r_cnt  <= bus.cmd_count;
      end else if (r_state == ST_SHIFT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == ST_DONE) begin
        r_result <= bus.A_par;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_s1        = 1'b0;
    w_s0        = 1'b0;
    w_msb       = 1'b0;
    w_lsb       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_s1        = 1'b1;
        w_s0        = 1'b1;
        w_state_nxt = (r_cnt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (r_dir) begin
          w_s1  = 1'b1;
          w_lsb = w_fill;
        end else begin
          w_s0  = 1'b1;
          w_msb = w_fill;
        end
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = w_ready;
  assign bus.s1        = w_s1;
  assign bus.s0        = w_s0;
  assign bus.I_par     = r_data;
  assign bus.MSB_in    = w_msb;
  assign bus.LSB_in    = w_lsb;
  assign bus.done      = r_done;
  assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_sequencer.sv
`default_nettype none
// Bench for shift_register_sequencer: models the owned universal shift register
// and compares results, latency and select sequences against a shift-arithmetic model.
module tb_shift_register_sequencer;
  localparam int W  = 3;
  localparam int CW = 4;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Clear = 1'b1;
  int   checks = 0;
  int   failures = 0;

  shift_register_sequencer_if #(.W(W), .CW(CW)) bus ();

  shift_register_sequencer #(.W(W), .CW(CW)) dut (
    .CLK   (CLK),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // The universal shift register the sequencer drives.
  logic [W-1:0] reg_q = '0;
  always @(posedge CLK) begin
    case ({bus.s1, bus.s0})
      2'b01:   reg_q <= {bus.MSB_in, reg_q[W-1:1]};
      2'b10:   reg_q <= {reg_q[W-2:0], bus.LSB_in};
      2'b11:   reg_q <= bus.I_par;
      default: reg_q <= reg_q;
    endcase
  end
  assign bus.A_par = reg_q;

  // Expected final value from plain integer shift arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dir,
                                         input int cnt, input logic ser, input logic rot);
    int v;
    int out;
    int fill;
    v = int'(d);
    for (int i = 0; i < cnt; i++) begin
      if (!dir) begin
        out  = v % 2;
        fill = (ROT_EN && rot) ? out : int'(ser);
        v    = v / 2 + fill * (2 ** (W - 1));
      end else begin
        out  = v / (2 ** (W - 1));
        fill = (ROT_EN && rot) ? out : int'(ser);
        v    = (v * 2) % (2 ** W) + fill;
      end
    end
    return v[W-1:0];
  endfunction

  logic [1:0]   sels[$];
  logic [1:0]   exp_sels[$];
  bit           unused_bad;
  int           lat;
  logic [W-1:0] res;
  logic [W-1:0] ipar;

  function automatic void build_exp(input logic dir, input int cnt);
    exp_sels.delete();
    exp_sels.push_back(2'b11);
    for (int i = 0; i < cnt; i++) exp_sels.push_back(dir ? 2'b10 : 2'b01);
    exp_sels.push_back(2'b00);
  endfunction

  function automatic bit sels_differ();
    if (sels.size() != exp_sels.size()) return 1'b1;
    foreach (sels[i]) if (sels[i] !== exp_sels[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Issues one command from IDLE and observes it until done (bounded).
  task automatic run_cmd(input logic [W-1:0] d, input logic dir, input logic [CW-1:0] cnt,
                         input logic ser, input logic rot);
    logic [1:0] s;
    sels.delete();
    unused_bad = 1'b0;
    lat = -1;
    res = 'x;
    ipar = 'x;
    @(negedge CLK);
    bus.cmd_data = d; bus.cmd_dir = dir; bus.cmd_count = cnt;
    bus.cmd_ser = ser; bus.cmd_rot = rot; bus.cmd_valid = 1'b1;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = W'($urandom);
    bus.cmd_dir   = 1'($urandom);
    bus.cmd_count = CW'($urandom);
    bus.cmd_ser   = 1'($urandom);
    bus.cmd_rot   = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      s = {bus.s1, bus.s0};
      sels.push_back(s);
      if ((s != 2'b01 && bus.MSB_in) || (s != 2'b10 && bus.LSB_in)) unused_bad = 1'b1;
      @(posedge CLK); #1;
      if (bus.done === 1'b1) begin
        lat = k; res = bus.result; ipar = bus.I_par;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks += 7;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    if ({bus.s1, bus.s0} !== 2'b00) begin failures++; $display("FAIL reset_sel: got %b expected 00", {bus.s1, bus.s0}); end
    if (bus.I_par !== '0) begin failures++; $display("FAIL reset_ipar: got %b expected 000", bus.I_par); end
    if (bus.MSB_in !== 1'b0) begin failures++; $display("FAIL reset_msb: got %b expected 0", bus.MSB_in); end
    if (bus.LSB_in !== 1'b0) begin failures++; $display("FAIL reset_lsb: got %b expected 0", bus.LSB_in); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.result !== '0) begin failures++; $display("FAIL reset_result: got %b expected 000", bus.result); end
    Clear = 1'b0;
  endtask

  task automatic test_abort();
    logic [W-1:0] held;
    bit done_seen;
    bit reg_moved;
    @(negedge CLK);
    bus.cmd_data = 3'b101; bus.cmd_dir = 1'b0; bus.cmd_count = 4'd5;
    bus.cmd_ser = 1'b1; bus.cmd_rot = 1'b0; bus.cmd_valid = 1'b1;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Clear = 1'b1;
    @(posedge CLK); #1;
    Clear = 1'b0;
    checks += 3;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", bus.cmd_ready); end
    if ({bus.s1, bus.s0} !== 2'b00) begin failures++; $display("FAIL abort_sel: got %b expected 00", {bus.s1, bus.s0}); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done_now: got %b expected 0", bus.done); end
    held = reg_q;
    done_seen = 1'b0;
    reg_moved = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (bus.done !== 1'b0) done_seen = 1'b1;
      if (reg_q !== held) reg_moved = 1'b1;
    end
    checks += 3;
    if (done_seen) begin failures++; $display("FAIL abort_no_done: got 1 expected 0"); end
    if (reg_moved) begin failures++; $display("FAIL abort_reg_hold: got %b expected %b", reg_q, held); end
    if (bus.result !== '0) begin failures++; $display("FAIL abort_result: got %b expected 000", bus.result); end
  endtask

  task automatic test_directed();
    logic [W-1:0]  td[5];
    logic          tdir[5];
    logic [CW-1:0] tcnt[5];
    logic          tser[5];
    logic          trot[5];
    logic [W-1:0]  texp[5];
    td[0] = 3'b101; tdir[0] = 0; tcnt[0] = 1; tser[0] = 1; trot[0] = 0; texp[0] = 3'b110;
    td[1] = 3'b101; tdir[1] = 1; tcnt[1] = 2; tser[1] = 0; trot[1] = 0; texp[1] = 3'b100;
    td[2] = 3'b011; tdir[2] = 0; tcnt[2] = 0; tser[2] = 1; trot[2] = 0; texp[2] = 3'b011;
    td[3] = 3'b101; tdir[3] = 0; tcnt[3] = 1; tser[3] = 0; trot[3] = 1; texp[3] = ROT_EN ? 3'b110 : 3'b010;
    td[4] = 3'b101; tdir[4] = 1; tcnt[4] = 4; tser[4] = 0; trot[4] = 1; texp[4] = ROT_EN ? 3'b011 : 3'b000;
    for (int i = 0; i < 5; i++) begin
      run_cmd(td[i], tdir[i], tcnt[i], tser[i], trot[i]);
      build_exp(tdir[i], int'(tcnt[i]));
      checks += 3;
      if (lat != int'(tcnt[i]) + 2) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, int'(tcnt[i]) + 2); end
      if (res !== texp[i]) begin failures++; $display("FAIL dir%0d_result: got %b expected %b", i, res, texp[i]); end
      if (sels_differ()) begin failures++; $display("FAIL dir%0d_selects: got %p expected %p", i, sels, exp_sels); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  d;
    logic          dir, ser, rot;
    logic [CW-1:0] cnt;
    logic [W-1:0]  exp_r;
    for (int n = 0; n < 30; n++) begin
      d = W'($urandom); dir = 1'($urandom); cnt = CW'($urandom_range(0, 15));
      ser = 1'($urandom); rot = 1'($urandom);
      exp_r = model(d, dir, int'(cnt), ser, rot);
      run_cmd(d, dir, cnt, ser, rot);
      build_exp(dir, int'(cnt));
      checks += 5;
      if (lat != int'(cnt) + 2) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, int'(cnt) + 2); end
      if (res !== exp_r) begin failures++; $display("FAIL rnd%0d_result: got %b expected %b", n, res, exp_r); end
      if (ipar !== d) begin failures++; $display("FAIL rnd%0d_ipar_hold: got %b expected %b", n, ipar, d); end
      if (sels_differ()) begin failures++; $display("FAIL rnd%0d_selects: got %p expected %p", n, sels, exp_sels); end
      if (unused_bad) begin failures++; $display("FAIL rnd%0d_unused_serial: got 1 expected 0", n); end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [W-1:0] r1, r2;
    logic ready_in_done;
    bit busy_ready;
    lat1 = -1; lat2 = -1; r1 = 'x; r2 = 'x; ready_in_done = 1'b0; busy_ready = 1'b0;
    @(negedge CLK);
    bus.cmd_data = 3'b110; bus.cmd_dir = 1'b1; bus.cmd_count = 4'd3;
    bus.cmd_ser = 1'b1; bus.cmd_rot = 1'b0; bus.cmd_valid = 1'b1;
    @(posedge CLK); #1;
    for (int k = 1; k <= 40; k++) begin
      if (bus.cmd_ready !== 1'b0) busy_ready = 1'b1;
      @(posedge CLK); #1;
      if (bus.done === 1'b1) begin
        lat1 = k; r1 = bus.result; ready_in_done = bus.cmd_ready;
        break;
      end
    end
    bus.cmd_data = 3'b001; bus.cmd_dir = 1'b0; bus.cmd_count = 4'd2; bus.cmd_ser = 1'b1;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (bus.done === 1'b1) begin
        lat2 = k; r2 = bus.result;
        break;
      end
    end
    checks += 6;
    if (lat1 != 5) begin failures++; $display("FAIL b2b_latency1: got %0d expected 5", lat1); end
    if (r1 !== model(3'b110, 1'b1, 3, 1'b1, 1'b0)) begin failures++; $display("FAIL b2b_result1: got %b expected %b", r1, model(3'b110, 1'b1, 3, 1'b1, 1'b0)); end
    if (busy_ready) begin failures++; $display("FAIL b2b_busy_ready: got 1 expected 0"); end
    if (ready_in_done !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done: got %b expected 1", ready_in_done); end
    if (lat2 != 4) begin failures++; $display("FAIL b2b_latency2: got %0d expected 4", lat2); end
    if (r2 !== model(3'b001, 1'b0, 2, 1'b1, 1'b0)) begin failures++; $display("FAIL b2b_result2: got %b expected %b", r2, model(3'b001, 1'b0, 2, 1'b1, 1'b0)); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_ser   = 1'b0;
    bus.cmd_rot   = 1'b0;
    test_reset();
    test_abort();
    test_directed();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
